mastermind_solver: RTL and testbench

- Codebreaker engine for the reversed game mode: the machine proposes guesses and the player scores them.
- Guesses drive the same 4-peg, 3-bit-colour path as the player-guess block: LED driver inputs plus history.
- The player enters feedback as exact/partial counts. The block prunes the code space by consistency search and presents the next consistent code.
- Sits beside the player-guess block, selected by the mode switch, clocked from the system clock.

---
 rtl/mastermind_solver.sv | 167 ++++++++++++++++
 tb/tb_mastermind_solver.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mastermind_solver.sv
// Codebreaker engine: proposes 4-peg / 8-colour guesses, takes exact/partial
// feedback from the player and walks the code space upward until it finds the
// next candidate that agrees with every stored feedback entry.
module mastermind_solver #(
  parameter int unsigned MAX_TURNS = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       fb_valid,
  input  logic [2:0] fb_exact,
  input  logic [2:0] fb_partial,
  output logic [2:0] guess0,
  output logic [2:0] guess1,
  output logic [2:0] guess2,
  output logic [2:0] guess3,
  output logic       guess_valid,
  output logic       busy,
  output logic [3:0] turn,
  output logic       solved,
  output logic       failed,
  output logic       fb_error
);

  typedef enum logic [2:0] {IDLE, SEARCH, PRESENT, SOLVED, FAIL} state_t;

  state_t      state;
  logic [11:0] cand;
  logic [11:0] hist_guess   [MAX_TURNS];
  logic [2:0]  hist_exact   [MAX_TURNS];
  logic [2:0]  hist_partial [MAX_TURNS];

  logic        consistent;
  logic [3:0]  fb_sum;
  logic        fb_illegal;
  logic        last_turn;

  // Score of code a against code b, packed as {exact, partial}.
  function automatic logic [5:0] score(input logic [11:0] a, input logic [11:0] b);
    logic [2:0] ex;
    logic [2:0] tot;
    logic [2:0] na;
    logic [2:0] nb;
    ex  = '0;
    tot = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (a[3*i +: 3] == b[3*i +: 3]) ex = ex + 3'd1;
    for (int unsigned c = 0; c < 8; c++) begin
      na = '0;
      nb = '0;
      for (int unsigned i = 0; i < 4; i++) begin
        if (a[3*i +: 3] == 3'(c)) na = na + 3'd1;
        if (b[3*i +: 3] == 3'(c)) nb = nb + 3'd1;
      end
      tot = tot + ((na < nb) ? na : nb);
    end
    return {ex, tot - ex};
  endfunction

  // Current candidate checked against all live history entries in parallel.
  always_comb begin
    consistent = 1'b1;
    for (int unsigned k = 0; k < MAX_TURNS; k++)
      if (k < 32'(turn) &&
          score(cand, hist_guess[k]) != {hist_exact[k], hist_partial[k]})
        consistent = 1'b0;
  end

  // Feedback legality and end-of-turns detection.
  always_comb begin
    fb_sum     = {1'b0, fb_exact} + {1'b0, fb_partial};
    fb_illegal = (fb_sum > 4'd4) || (fb_exact == 3'd3 && fb_partial == 3'd1);
    last_turn  = (({1'b0, turn} + 5'd1) == 5'(MAX_TURNS));
  end

  // Main controller: state, search pointer, history and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cand        <= '0;
      turn        <= '0;
      guess0      <= '0;
      guess1      <= '0;
      guess2      <= '0;
      guess3      <= '0;
      guess_valid <= 1'b0;
      busy        <= 1'b0;
      solved      <= 1'b0;
      failed      <= 1'b0;
      fb_error    <= 1'b0;
      for (int unsigned k = 0; k < MAX_TURNS; k++) begin
        hist_guess[k]   <= '0;
        hist_exact[k]   <= '0;
        hist_partial[k] <= '0;
      end
    end else if (start) begin
      state       <= SEARCH;
      cand        <= '0;
      turn        <= '0;
      guess_valid <= 1'b0;
      busy        <= 1'b1;
      solved      <= 1'b0;
      failed      <= 1'b0;
      fb_error    <= 1'b0;
      for (int unsigned k = 0; k < MAX_TURNS; k++) begin
        hist_guess[k]   <= '0;
        hist_exact[k]   <= '0;
        hist_partial[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: ;
        SEARCH: begin
          if (consistent) begin
            guess0      <= cand[2:0];
            guess1      <= cand[5:3];
            guess2      <= cand[8:6];
            guess3      <= cand[11:9];
            guess_valid <= 1'b1;
            busy        <= 1'b0;
            state       <= PRESENT;
          end else if (cand == '1) begin
            busy   <= 1'b0;
            failed <= 1'b1;
            state  <= FAIL;
          end else begin
            cand <= cand + 12'd1;
          end
        end
        PRESENT: begin
          if (fb_valid) begin
            guess_valid <= 1'b0;
            if (fb_illegal) begin
              fb_error <= 1'b1;
              failed   <= 1'b1;
              state    <= FAIL;
            end else if (fb_exact == 3'd4) begin
              solved <= 1'b1;
              state  <= SOLVED;
            end else begin
              // cand still holds the presented guess while in PRESENT
              for (int unsigned k = 0; k < MAX_TURNS; k++)
                if (k == 32'(turn)) begin
                  hist_guess[k]   <= cand;
                  hist_exact[k]   <= fb_exact;
                  hist_partial[k] <= fb_partial;
                end
              if (last_turn || cand == '1) begin
                failed <= 1'b1;
                state  <= FAIL;
              end else begin
                turn  <= turn + 4'd1;
                cand  <= cand + 12'd1;
                busy  <= 1'b1;
                state <= SEARCH;
              end
            end
          end
        end
        SOLVED: ;
        FAIL: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mastermind_solver.sv
// Bench for mastermind_solver: a per-cycle vector table for the feedback
// legality paths, directed sequences for latency / reset / turn limit, and
// random secrets played against a reference codebreaker model.
module tb_mastermind_solver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, fb_valid;
  logic [2:0] fb_exact, fb_partial;
  logic [2:0] guess0, guess1, guess2, guess3;
  logic       guess_valid, busy, solved, failed, fb_error;
  logic [3:0] turn;

  logic       start2, fb_valid2;
  logic [2:0] fb_exact2, fb_partial2;
  logic [2:0] g20, g21, g22, g23;
  logic       gv2, busy2, solved2, failed2, err2;
  logic [3:0] turn2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mastermind_solver #(.MAX_TURNS(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .fb_valid(fb_valid),
    .fb_exact(fb_exact), .fb_partial(fb_partial),
    .guess0(guess0), .guess1(guess1), .guess2(guess2), .guess3(guess3),
    .guess_valid(guess_valid), .busy(busy), .turn(turn),
    .solved(solved), .failed(failed), .fb_error(fb_error)
  );

  mastermind_solver #(.MAX_TURNS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .fb_valid(fb_valid2),
    .fb_exact(fb_exact2), .fb_partial(fb_partial2),
    .guess0(g20), .guess1(g21), .guess2(g22), .guess3(g23),
    .guess_valid(gv2), .busy(busy2), .turn(turn2),
    .solved(solved2), .failed(failed2), .fb_error(err2)
  );

  typedef struct {
    logic       st;
    logic       fbv;
    logic [2:0] ex;
    logic [2:0] pa;
    logic       e_gv;
    logic       e_busy;
    logic       e_solved;
    logic       e_failed;
    logic       e_err;
    logic [3:0] e_turn;
  } vec_t;

  vec_t tbl[14];

  int hg[$];
  int he[$];
  int hp[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cur_guess();
    return 32'({guess3, guess2, guess1, guess0});
  endfunction

  // Reference scoring straight from the game rules: colour histograms.
  function automatic void mscore(input int a, input int b, output int ex, output int pa);
    int ca[8];
    int cb[8];
    int tot;
    int x;
    int y;
    ex  = 0;
    tot = 0;
    for (int c = 0; c < 8; c++) begin
      ca[c] = 0;
      cb[c] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      x = (a >> (3 * i)) & 7;
      y = (b >> (3 * i)) & 7;
      if (x == y) ex++;
      ca[x]++;
      cb[y]++;
    end
    for (int c = 0; c < 8; c++) tot += (ca[c] < cb[c]) ? ca[c] : cb[c];
    pa = tot - ex;
  endfunction

  // Smallest code >= from agreeing with every recorded feedback, or -1.
  function automatic int model_next(input int from);
    int ex;
    int pa;
    bit ok;
    for (int c = from; c < 4096; c++) begin
      ok = 1'b1;
      foreach (hg[k]) begin
        mscore(c, hg[k], ex, pa);
        if (ex != he[k] || pa != hp[k]) ok = 1'b0;
      end
      if (ok) return c;
    end
    return -1;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic give_fb(input int ex, input int pa);
    fb_valid   = 1'b1;
    fb_exact   = 3'(ex);
    fb_partial = 3'(pa);
    tick();
    fb_valid   = 1'b0;
    fb_exact   = '0;
    fb_partial = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_guess"}, cur_guess(), 0);
    chk({tag, "_gv"}, 32'(guess_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_turn"}, 32'(turn), 0);
    chk({tag, "_solved"}, 32'(solved), 0);
    chk({tag, "_failed"}, 32'(failed), 0);
    chk({tag, "_fberr"}, 32'(fb_error), 0);
  endtask

  initial begin
    int cnt;
    int secret;
    int expg;
    int g;
    int ex;
    int pa;
    int from;
    int tm;
    bit done;

    reset_n = 1'b0;
    start = 1'b0; fb_valid = 1'b0; fb_exact = '0; fb_partial = '0;
    start2 = 1'b0; fb_valid2 = 1'b0; fb_exact2 = '0; fb_partial2 = '0;
    #12;
    check_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // st fbv ex pa | gv busy solved failed err turn
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[2]  = '{1'b0, 1'b1, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0};
    tbl[3]  = '{1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0};
    tbl[4]  = '{1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[5]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[6]  = '{1'b0, 1'b1, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0};
    tbl[7]  = '{1'b1, 1'b1, 3'd4, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[8]  = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[9]  = '{1'b0, 1'b1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0};
    tbl[10] = '{1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[11] = '{1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[12] = '{1'b0, 1'b1, 3'd4, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[13] = '{1'b0, 1'b1, 3'd4, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0};

    for (int i = 0; i < 14; i++) begin
      start = tbl[i].st; fb_valid = tbl[i].fbv;
      fb_exact = tbl[i].ex; fb_partial = tbl[i].pa;
      tick();
      start = 1'b0; fb_valid = 1'b0; fb_exact = '0; fb_partial = '0;
      chk($sformatf("vec%0d_gv", i), 32'(guess_valid), 32'(tbl[i].e_gv));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d_solved", i), 32'(solved), 32'(tbl[i].e_solved));
      chk($sformatf("vec%0d_failed", i), 32'(failed), 32'(tbl[i].e_failed));
      chk($sformatf("vec%0d_fberr", i), 32'(fb_error), 32'(tbl[i].e_err));
      chk($sformatf("vec%0d_turn", i), 32'(turn), 32'(tbl[i].e_turn));
      chk($sformatf("vec%0d_guess", i), cur_guess(), 0);
    end

    // Full-sweep latency: 0/0 on 0000 skips every code containing colour 0.
    pulse_start();
    tick();
    chk("lat_gv0", 32'(guess_valid), 1);
    give_fb(0, 0);
    cnt = 0;
    while (busy && cnt < 5000) begin
      cnt++;
      tick();
    end
    chk("lat_busy_cycles", cnt, 585);
    chk("lat_gv1", 32'(guess_valid), 1);
    chk("lat_guess1", cur_guess(), 'h249);
    chk("lat_turn1", 32'(turn), 1);

    // Asynchronous reset in the middle of a search.
    give_fb(0, 0);
    tick(); tick(); tick();
    chk("midrst_busy_pre", 32'(busy), 1);
    reset_n = 1'b0;
    #2;
    check_all_zero("midrst");
    #1;
    reset_n = 1'b1;
    tick();
    pulse_start();
    tick();
    chk("midrst_restart_gv", 32'(guess_valid), 1);
    chk("midrst_restart_guess", cur_guess(), 0);
    chk("midrst_restart_turn", 32'(turn), 0);

    // Turn limit with a two-entry history.
    start2 = 1'b1; tick(); start2 = 1'b0;
    tick();
    chk("mt2_gv0", 32'(gv2), 1);
    fb_valid2 = 1'b1; tick(); fb_valid2 = 1'b0;
    cnt = 0;
    while (!gv2 && cnt < 5000) begin
      cnt++;
      tick();
    end
    chk("mt2_gv1", 32'(gv2), 1);
    chk("mt2_turn1", 32'(turn2), 1);
    chk("mt2_guess1", 32'({g23, g22, g21, g20}), 'h249);
    fb_valid2 = 1'b1; tick(); fb_valid2 = 1'b0;
    chk("mt2_failed", 32'(failed2), 1);
    chk("mt2_turn_end", 32'(turn2), 1);
    chk("mt2_solved", 32'(solved2), 0);
    chk("mt2_gv_end", 32'(gv2), 0);

    // Random secrets, feedback from the reference scorer.
    for (g = 0; g < 16; g++) begin
      secret = int'($urandom_range(0, 4095));
      hg.delete(); he.delete(); hp.delete();
      pulse_start();
      from = 0;
      tm = 0;
      done = 1'b0;
      while (!done) begin
        cnt = 0;
        while (!(guess_valid || failed || solved) && cnt < 6000) begin
          cnt++;
          tick();
        end
        if (cnt >= 6000) begin
          chk($sformatf("g%0d_timeout", g), 1, 0);
          done = 1'b1;
        end else begin
          expg = model_next(from);
          if (expg < 0) begin
            chk($sformatf("g%0d_exhaust_failed", g), 32'(failed), 1);
            done = 1'b1;
          end else begin
            chk($sformatf("g%0d_t%0d_gv", g, tm), 32'(guess_valid), 1);
            chk($sformatf("g%0d_t%0d_guess", g, tm), cur_guess(), expg);
            chk($sformatf("g%0d_t%0d_turn", g, tm), 32'(turn), tm);
            mscore(secret, cur_guess(), ex, pa);
            hg.push_back(cur_guess()); he.push_back(ex); hp.push_back(pa);
            give_fb(ex, pa);
            if (ex == 4) begin
              chk($sformatf("g%0d_solved", g), 32'(solved), 1);
              chk($sformatf("g%0d_final_guess", g), cur_guess(), secret);
              chk($sformatf("g%0d_final_turn", g), 32'(turn), tm);
              chk($sformatf("g%0d_final_gv", g), 32'(guess_valid), 0);
              done = 1'b1;
            end else if (tm + 1 == 8) begin
              chk($sformatf("g%0d_failed", g), 32'(failed), 1);
              chk($sformatf("g%0d_fail_turn", g), 32'(turn), 7);
              chk($sformatf("g%0d_fail_solved", g), 32'(solved), 0);
              done = 1'b1;
            end else begin
              tm++;
              from = expg + 1;
            end
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
